alu_stim_gen: RTL and testbench

Parametrised, handshaked stimulus generator for the ALU datapath bench. It drives operand pairs R/S, carry-in CI and function select ALB_MI from one of four generation modes, for a programmable burst length, with optional looping. It sits between the bench controller (start/abort/mode) and the ALU under test (valid/ready), and replaces the fixed 8-vector free-running generator.

---
 rtl/alu_stim_gen.sv | 209 ++++++++++++++++++++
 tb/tb_alu_stim_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stim_gen.sv
// alu_stim_gen: handshaked R/S/CI/ALB_MI stimulus generator for the ALU datapath bench.
// Optional LFSR random mode (mode 1) is built in when STIM_LFSR_EN is defined.
module alu_stim_gen #(
    parameter int          WIDTH     = 8,
    parameter int          FN_W      = 2,
    parameter int          NUM_VEC   = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 mode,
    input  logic                       loop,
    input  logic                       ready,
    output logic [WIDTH-1:0]           R,
    output logic [WIDTH-1:0]           S,
    output logic                       CI,
    output logic [FN_W-1:0]            ALB_MI,
    output logic                       valid,
    output logic [$clog2(NUM_VEC)-1:0] vec_idx,
    output logic                       busy,
    output logic                       done
);
    localparam int               IDX_W    = $clog2(NUM_VEC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_RUN   = 2'd1;
    localparam logic [1:0]       ST_DONE  = 2'd2;
    localparam logic [WIDTH-1:0] ONE_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [15:0] dir_pair(input logic [2:0] sel);
        logic [15:0] p;
        case (sel)
            3'd0:    p = 16'h5533;
            3'd1:    p = 16'hAA0F;
            3'd2:    p = 16'h0FF0;
            3'd3:    p = 16'hFF00;
            3'd4:    p = 16'h0A05;
            3'd5:    p = 16'hF00F;
            3'd6:    p = 16'h3CC3;
            default: p = 16'hAA55;
        endcase
        return p;
    endfunction

    logic [1:0]       state_r, nxt_state_s;
    logic [IDX_W-1:0] idx_r, nxt_idx_s;
    logic [1:0]       mode_r, nxt_mode_s;
    logic             loop_r, nxt_loop_s;
    logic             accept_s;
    logic [31:0]      idx_ext_s;
    logic [15:0]      pair_s;
    logic [WIDTH-1:0] gen_r_s, gen_s_s;
    logic             gen_ci_s;
    logic [FN_W-1:0]  gen_fn_s;

    assign accept_s  = valid & ready;
    assign idx_ext_s = 32'(nxt_idx_s);

`ifdef STIM_LFSR_EN
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    logic [31:0] lfsr_r, nxt_lfsr_s;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // LFSR restarts from the seed on start and steps once per accepted vector (not reloaded at loop wrap).
    always_comb begin
        nxt_lfsr_s = lfsr_r;
        if (abort) begin
            nxt_lfsr_s = lfsr_r;
        end else if ((state_r == ST_IDLE) && start) begin
            nxt_lfsr_s = LFSR_SEED;
        end else if ((state_r == ST_RUN) && accept_s) begin
            nxt_lfsr_s = lfsr_step(lfsr_r);
        end else begin
            nxt_lfsr_s = lfsr_r;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= nxt_lfsr_s;
        end
    end
`endif

    // Burst sequencing: abort wins over everything; index only moves on accept.
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = idx_r;
        nxt_mode_s  = mode_r;
        nxt_loop_s  = loop_r;
        if (abort) begin
            nxt_state_s = ST_IDLE;
            nxt_idx_s   = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        nxt_state_s = ST_RUN;
                        nxt_idx_s   = {IDX_W{1'b0}};
                        nxt_mode_s  = mode;
                        nxt_loop_s  = loop;
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (accept_s && (idx_r == LAST_IDX)) begin
                        nxt_idx_s   = {IDX_W{1'b0}};
                        nxt_state_s = loop_r ? ST_RUN : ST_DONE;
                    end else if (accept_s) begin
                        nxt_idx_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end else begin
                        nxt_idx_s = idx_r;
                    end
                end
                ST_DONE: begin
                    nxt_state_s = ST_IDLE;
                end
                default: begin
                    nxt_state_s = ST_IDLE;
                    nxt_idx_s   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Vector decode from the upcoming index/mode so the registered outputs carry no bubble.
    always_comb begin
        pair_s   = dir_pair(idx_ext_s[2:0]);
        gen_r_s  = {(WIDTH/8){pair_s[15:8]}};
        gen_s_s  = {(WIDTH/8){pair_s[7:0]}};
        gen_ci_s = ~idx_ext_s[0];
        gen_fn_s = FN_W'(idx_ext_s[1:0]);
        case (nxt_mode_s)
`ifdef STIM_LFSR_EN
            2'd1: begin
                gen_r_s  = nxt_lfsr_s[WIDTH-1:0];
                gen_s_s  = ~nxt_lfsr_s[31:32-WIDTH];
                gen_ci_s = nxt_lfsr_s[16];
                gen_fn_s = nxt_lfsr_s[8+FN_W-1:8];
            end
`endif
            2'd2: begin
                gen_r_s  = ONE_LSB << (idx_ext_s % WIDTH);
                gen_s_s  = ~(ONE_LSB << (idx_ext_s % WIDTH));
                gen_ci_s = idx_ext_s[0];
                gen_fn_s = idx_ext_s[FN_W-1:0];
            end
            2'd3: begin
                gen_r_s               = {(WIDTH/8){8'h55}};
                gen_s_s               = {(WIDTH/8){8'h33}};
                {gen_fn_s, gen_ci_s}  = idx_ext_s[FN_W:0];
            end
            default: begin
                gen_r_s  = {(WIDTH/8){pair_s[15:8]}};
                gen_s_s  = {(WIDTH/8){pair_s[7:0]}};
                gen_ci_s = ~idx_ext_s[0];
                gen_fn_s = FN_W'(idx_ext_s[1:0]);
            end
        endcase
    end

    // State and registered outputs; everything is zero outside RUN.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            mode_r  <= 2'd0;
            loop_r  <= 1'b0;
            R       <= {WIDTH{1'b0}};
            S       <= {WIDTH{1'b0}};
            CI      <= 1'b0;
            ALB_MI  <= {FN_W{1'b0}};
            valid   <= 1'b0;
            vec_idx <= {IDX_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            idx_r   <= nxt_idx_s;
            mode_r  <= nxt_mode_s;
            loop_r  <= nxt_loop_s;
            valid   <= (nxt_state_s == ST_RUN);
            busy    <= (nxt_state_s == ST_RUN);
            done    <= (nxt_state_s == ST_DONE);
            vec_idx <= nxt_idx_s;
            if (nxt_state_s == ST_RUN) begin
                R      <= gen_r_s;
                S      <= gen_s_s;
                CI     <= gen_ci_s;
                ALB_MI <= gen_fn_s;
            end else begin
                R      <= {WIDTH{1'b0}};
                S      <= {WIDTH{1'b0}};
                CI     <= 1'b0;
                ALB_MI <= {FN_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_alu_stim_gen.sv
// Self-checking bench for alu_stim_gen (WIDTH=16, FN_W=3, NUM_VEC=20) against a behavioural burst model.
module tb_alu_stim_gen;
    localparam int          WIDTH   = 16;
    localparam int          FN_W    = 3;
    localparam int          NUM_VEC = 20;
    localparam int          IW      = $clog2(NUM_VEC);
    localparam logic [31:0] SEED    = 32'hACE1_2468;

    logic             clk = 1'b0;
    logic             resetb = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             loop = 1'b0;
    logic             ready = 1'b0;
    logic [WIDTH-1:0] R, S;
    logic             CI;
    logic [FN_W-1:0]  ALB_MI;
    logic             valid;
    logic [IW-1:0]    vec_idx;
    logic             busy;
    logic             done;

    alu_stim_gen #(.WIDTH(WIDTH), .FN_W(FN_W), .NUM_VEC(NUM_VEC), .LFSR_SEED(SEED)) u_dut (
        .clk(clk), .resetb(resetb), .start(start), .abort(abort), .mode(mode), .loop(loop),
        .ready(ready), .R(R), .S(S), .CI(CI), .ALB_MI(ALB_MI), .valid(valid),
        .vec_idx(vec_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    int          done_seen = 0;
    int          m_phase;   // 0 idle, 1 running, 2 finishing
    int          m_idx;
    int          m_mode;
    bit          m_loop;
    logic [31:0] m_lfsr;
    logic [43:0] last_obs, last_exp;
    logic [43:0] burst_q[$];
    logic [7:0]  dir_r[8] = '{8'h55, 8'hAA, 8'h0F, 8'hFF, 8'h0A, 8'hF0, 8'h3C, 8'hAA};
    logic [7:0]  dir_s[8] = '{8'h33, 8'h0F, 8'hF0, 8'h00, 8'h05, 8'h0F, 8'hC3, 8'h55};

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    function automatic logic [43:0] expect_out();
        logic [15:0] r, s;
        logic        ci;
        logic [2:0]  fn;
        int          md;
        if (m_phase != 1) return {43'b0, (m_phase == 2)};
        md = m_mode;
`ifndef STIM_LFSR_EN
        if (md == 1) md = 0;
`endif
        case (md)
            0: begin
                r = {2{dir_r[m_idx % 8]}}; s = {2{dir_s[m_idx % 8]}};
                ci = ((m_idx % 2) == 0); fn = 3'(m_idx % 4);
            end
            1: begin
                r = m_lfsr[15:0]; s = ~m_lfsr[31:16]; ci = m_lfsr[16]; fn = m_lfsr[10:8];
            end
            2: begin
                r = 16'd1 << (m_idx % 16); s = ~r; ci = ((m_idx % 2) == 1); fn = 3'(m_idx % 8);
            end
            default: begin
                r = 16'h5555; s = 16'h3333; ci = ((m_idx % 2) == 1); fn = 3'((m_idx / 2) % 8);
            end
        endcase
        return {r, s, ci, fn, 1'b1, 5'(m_idx), 1'b1, 1'b0};
    endfunction

    task automatic model_step();
        if (abort) begin
            m_phase = 0; m_idx = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_idx = 0; m_mode = int'(mode); m_loop = loop; m_lfsr = SEED;
                end
                1: if (ready) begin
                    m_lfsr = lfsr_next(m_lfsr);
                    if (m_idx == NUM_VEC - 1) begin
                        m_idx = 0;
                        if (!m_loop) m_phase = 2;
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [43:0] observe();
        return {R, S, CI, ALB_MI, valid, vec_idx, busy, done};
    endfunction

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        last_exp = expect_out();
        last_obs = observe();
        if (done) done_seen++;
        check(tag, 64'(last_obs), 64'(last_exp));
    endtask

    initial begin
        m_phase = 0; m_idx = 0; m_mode = 0; m_loop = 1'b0; m_lfsr = SEED;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(observe()), 64'h0);
        @(negedge clk);
        resetb = 1'b1;
        tick("idle");

        // Mode 0, ready high: full burst, one done pulse.
        mode = 2'd0; loop = 1'b0; ready = 1'b1; start = 1'b1;
        tick("m0_start");
        start = 1'b0;
        check("m0_first_vec", 64'({R, S, CI, ALB_MI, vec_idx}), 64'({16'h5555, 16'h3333, 1'b1, 3'd0, 5'd0}));
        done_seen = 0;
        repeat (NUM_VEC + 2) tick("m0_run");
        check("m0_done_once", 64'(done_seen), 64'd1);

        // Mode 0, ready toggling: vector holds while ready is low.
        start = 1'b1;
        tick("m0t_start");
        start = 1'b0; ready = 1'b0;
        tick("m0t_hold");
        check("m0t_hold_vec", 64'({R, S, vec_idx}), 64'({16'h5555, 16'h3333, 5'd0}));
        for (int i = 0; i < 2 * NUM_VEC + 3; i++) begin
            ready = (i % 2 == 0);
            tick("m0_toggle");
        end

        // Mode 2 walking one with mid-burst mode/start changes ignored.
        mode = 2'd2; ready = 1'b1; start = 1'b1;
        tick("m2_start");
        start = 1'b0; mode = 2'd3;
        for (int i = 0; i < NUM_VEC + 2; i++) begin
            start = (i == 5);
            tick("m2_run");
        end
        start = 1'b0;

        // Mode 3 sweep with loop: no done, then abort.
        mode = 2'd3; loop = 1'b1; start = 1'b1;
        tick("m3_start");
        start = 1'b0; loop = 1'b0; done_seen = 0;
        repeat (2 * NUM_VEC + 5) tick("m3_loop");
        check("m3_no_done", 64'(done_seen), 64'd0);
        abort = 1'b1;
        tick("m3_abort");
        abort = 1'b0;
        check("abort_zero", 64'(observe()), 64'h0);
        tick("post_abort");

        // Mode 1 twice: second burst must reproduce the first.
        mode = 2'd1; loop = 1'b0; ready = 1'b1; start = 1'b1;
        tick("m1a_start");
        start = 1'b0;
`ifdef STIM_LFSR_EN
        check("m1_first", 64'({R, S}), 64'({16'h2468, 16'h531E}));
`else
        check("m1_first", 64'({R, S}), 64'({16'h5555, 16'h3333}));
`endif
        burst_q.push_back(last_exp);
        for (int i = 0; i < NUM_VEC; i++) begin
            tick("m1a_run");
            burst_q.push_back(last_exp);
        end
        tick("m1_gap");
        start = 1'b1;
        tick("m1b_start");
        start = 1'b0;
        check("m1_repeat", 64'(last_obs), 64'(burst_q[0]));
        for (int i = 1; i <= NUM_VEC; i++) begin
            tick("m1b_run");
            check("m1_repeat", 64'(last_obs), 64'(burst_q[i]));
        end
        tick("m1_end");

        // Randomised control traffic.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(3) == 0);
            abort = ($urandom_range(15) == 0);
            mode  = 2'($urandom_range(3));
            loop  = ($urandom_range(3) == 0);
            ready = ($urandom_range(2) != 0);
            tick("random");
        end
        start = 1'b0; abort = 1'b1;
        tick("rand_abort");
        abort = 1'b0;

        // Asynchronous reset mid-burst at idx 5.
        mode = 2'd0; loop = 1'b0; ready = 1'b1; start = 1'b1;
        tick("rst_start");
        start = 1'b0;
        repeat (5) tick("rst_run");
        check("rst_idx5", 64'(vec_idx), 64'd5);
        #2;
        resetb = 1'b0;
        #1;
        check("rst_async_zero", 64'(observe()), 64'h0);
        m_phase = 0; m_idx = 0; m_lfsr = SEED;
        @(negedge clk);
        resetb = 1'b1;
        start = 1'b1;
        tick("rst_restart");
        start = 1'b0;
        check("rst_first_vec", 64'({R, S, vec_idx, valid}), 64'({16'h5555, 16'h3333, 5'd0, 1'b1}));
        repeat (NUM_VEC + 2) tick("rst_finish");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
